// File: rtl/imc_seq_ctrl.sv
// imc_seq_ctrl: load -> read -> MAC sequencer driving the in-memory-computing macro strobes
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start, abort      job control (start sampled in IDLE only, abort wins over start)
//   busy              high in every state except IDLE
//   wt_valid/wt_ready host weight-beat handshake, wt_data = LANES*WW packed row
//   write_en/bankde/wbank_data   one registered write pulse per accepted beat
//   read_en, mac_en   read pulse then MAC_CYCLES-long MAC enable
//   imc_result/result/done       result capture with one-cycle done pulse
//
// Build option: define IMC_SEQ_CTRL_REUSE_EN to add input reuse_wt, which lets a
// job skip LOAD and reuse the banks written by the last completed load.
module imc_seq_ctrl #(
    parameter int BANK_COUNT = 4,
    parameter int LANES      = 16,
    parameter int WW         = 4,
    parameter int MAC_CYCLES = 10,
    parameter int RES_W      = 14,
    localparam int BW = (BANK_COUNT > 1) ? $clog2(BANK_COUNT) : 1,
    localparam int MW = (MAC_CYCLES > 1) ? $clog2(MAC_CYCLES) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
`ifdef IMC_SEQ_CTRL_REUSE_EN
    input  logic                reuse_wt,
`endif
    output logic                busy,
    input  logic                wt_valid,
    output logic                wt_ready,
    input  logic [LANES*WW-1:0] wt_data,
    output logic                write_en,
    output logic                read_en,
    output logic                mac_en,
    output logic [BW-1:0]       bankde,
    output logic [LANES*WW-1:0] wbank_data,
    input  logic [RES_W-1:0]    imc_result,
    output logic [RES_W-1:0]    result,
    output logic                done
);
    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, RD, MAC, CAP} state_t;

    state_t                state_q, state_d;
    logic [BW-1:0]         bank_cnt_q, bank_cnt_d;
    logic [MW-1:0]         mac_cnt_q, mac_cnt_d;
    logic                  write_en_q;
    logic [BW-1:0]         bankde_q;
    logic [LANES*WW-1:0]   wbank_q;
    logic [RES_W-1:0]      result_q;
    logic                  done_q;
    logic                  hs, last_bank, mac_last, cap_ok, reuse_go;

    assign hs        = wt_valid & wt_ready;
    assign last_bank = bank_cnt_q == BW'(BANK_COUNT - 1);
    assign mac_last  = mac_cnt_q == MW'(MAC_CYCLES - 1);
    assign cap_ok    = (state_q == CAP) & ~abort;

`ifdef IMC_SEQ_CTRL_REUSE_EN
    // Banks stay valid from the end of a full load until reset or a LOAD abort.
    logic wt_loaded_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wt_loaded_q <= 1'b0;
        else if (state_q == LOAD && state_d == FLUSH)
            wt_loaded_q <= 1'b1;
        else if (state_q == LOAD && abort)
            wt_loaded_q <= 1'b0;
    end
    assign reuse_go = reuse_wt & wt_loaded_q;
`else
    assign reuse_go = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Abort in IDLE also lands on IDLE, which is what gives it priority over start.
    always_comb begin
        state_d = state_q;
        if (abort)
            state_d = IDLE;
        else
            case (state_q)
                IDLE:    if (start) state_d = reuse_go ? RD : LOAD;
                LOAD:    if (hs && last_bank) state_d = FLUSH;
                FLUSH:   state_d = RD;
                RD:      state_d = MAC;
                MAC:     if (mac_last) state_d = CAP;
                CAP:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
    end

    always_comb begin
        bank_cnt_d = (state_q != LOAD) ? '0 :
                     !hs               ? bank_cnt_q :
                     last_bank         ? '0 : bank_cnt_q + BW'(1);
        mac_cnt_d  = (state_q == MAC && !abort && !mac_last) ? mac_cnt_q + MW'(1) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_cnt_q <= '0;
            mac_cnt_q  <= '0;
            write_en_q <= 1'b0;
            bankde_q   <= '0;
            wbank_q    <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            bank_cnt_q <= bank_cnt_d;
            mac_cnt_q  <= mac_cnt_d;
            write_en_q <= hs;
            done_q     <= cap_ok;
            if (hs) begin
                bankde_q <= bank_cnt_q;
                wbank_q  <= wt_data;
            end
            if (cap_ok)
                result_q <= imc_result;
        end
    end

    // wt_ready drops in the abort cycle so a beat offered alongside abort is refused.
    always_comb begin
        busy       = state_q != IDLE;
        wt_ready   = (state_q == LOAD) & ~abort;
        read_en    = state_q == RD;
        mac_en     = state_q == MAC;
        write_en   = write_en_q;
        bankde     = bankde_q;
        wbank_data = wbank_q;
        result     = result_q;
        done       = done_q;
    end
endmodule

// File: tb/tb_imc_seq_ctrl.sv
// tb_imc_seq_ctrl: table-driven cycle checks plus write/result scoreboards for imc_seq_ctrl
module tb_imc_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        wt_valid = 1'b0;
    logic [63:0] wt_data = '0;
    logic [13:0] imc_val = 14'd1234;
`ifdef IMC_SEQ_CTRL_REUSE_EN
    logic        reuse_wt = 1'b0;
`endif
    logic        busy, wt_ready, write_en, read_en, mac_en, done;
    logic [1:0]  bankde;
    logic [63:0] wbank_data;
    logic [13:0] result;

    always #5 clk = ~clk;

    imc_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
`ifdef IMC_SEQ_CTRL_REUSE_EN
        .reuse_wt   (reuse_wt),
`endif
        .busy       (busy),
        .wt_valid   (wt_valid),
        .wt_ready   (wt_ready),
        .wt_data    (wt_data),
        .write_en   (write_en),
        .read_en    (read_en),
        .mac_en     (mac_en),
        .bankde     (bankde),
        .wbank_data (wbank_data),
        .imc_result (imc_val),
        .result     (result),
        .done       (done)
    );

    typedef struct {
        bit st, ab, va;
        int bt;
        bit bu, rd, we, re, me, dn;
    } vec_t;

    typedef struct {
        logic [1:0]  bk;
        logic [63:0] d;
    } wexp_t;

    vec_t        tv[$];
    wexp_t       wq[$];
    logic [13:0] rq[$];
    int          total = 0;
    int          bad = 0;

    function automatic vec_t mk(input bit st, ab, va, input int bt, input bit bu, rd, we, re, me, dn);
        vec_t r;
        r.st = st; r.ab = ab; r.va = va; r.bt = bt;
        r.bu = bu; r.rd = rd; r.we = we; r.re = re; r.me = me; r.dn = dn;
        return r;
    endfunction

    function automatic logic [63:0] beat_row(input int b);
        logic [63:0] r;
        int v;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            v = (b == 0) ? k : (b == 1) ? 15 - k : (b == 2) ? 2 * ((k % 7) + 1) : 2 * (k % 8) + 1;
            r[k*4 +: 4] = 4'(v);
        end
        return r;
    endfunction

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", n, a, e);
        end
    endtask

    task automatic run_tbl(input string tag);
        vec_t  r;
        wexp_t w;
        for (int c = 0; c < tv.size(); c++) begin
            r = tv[c];
            start    = r.st;
            abort    = r.ab;
            wt_valid = r.va;
            wt_data  = r.va ? beat_row(r.bt) : {$urandom, $urandom};
            if (r.va && r.rd) begin
                w.bk = 2'(r.bt);
                w.d  = beat_row(r.bt);
                wq.push_back(w);
            end
            if (r.st && !r.ab && !r.bu)
                rq.push_back(imc_val);
            if (r.ab && r.bu)
                rq.delete();
            @(negedge clk);
            chk($sformatf("%s c%0d busy", tag, c), busy, r.bu);
            chk($sformatf("%s c%0d wt_ready", tag, c), wt_ready, r.rd);
            chk($sformatf("%s c%0d write_en", tag, c), write_en, r.we);
            chk($sformatf("%s c%0d read_en", tag, c), read_en, r.re);
            chk($sformatf("%s c%0d mac_en", tag, c), mac_en, r.me);
            chk($sformatf("%s c%0d done", tag, c), done, r.dn);
            chk($sformatf("%s c%0d strobe_excl", tag, c), 64'(int'(write_en) + int'(read_en) + int'(mac_en) <= 1), 1);
            if (write_en === 1'b1) begin
                if (wq.size() == 0)
                    chk($sformatf("%s c%0d extra_write", tag, c), 1, 0);
                else begin
                    w = wq.pop_front();
                    chk($sformatf("%s c%0d bankde", tag, c), bankde, w.bk);
                    chk($sformatf("%s c%0d wbank_data", tag, c), wbank_data, w.d);
                end
            end
            if (done === 1'b1) begin
                if (rq.size() == 0)
                    chk($sformatf("%s c%0d extra_done", tag, c), 1, 0);
                else
                    chk($sformatf("%s c%0d result", tag, c), result, rq.pop_front());
            end
            @(posedge clk);
            #1;
        end
        start    = 1'b0;
        abort    = 1'b0;
        wt_valid = 1'b0;
        chk({tag, " writes_pending"}, wq.size(), 0);
        chk({tag, " results_pending"}, rq.size(), 0);
    endtask

    task automatic build_nom(input int extra_st);
        tv.delete();
        for (int c = 0; c < 20; c++)
            tv.push_back(mk(c == 0 || c == extra_st, 0, c >= 1 && c <= 4, c - 1, c >= 1 && c <= 17,
                            c >= 1 && c <= 4, c >= 2 && c <= 5, c == 6, c >= 7 && c <= 16, c == 18));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset wt_ready", wt_ready, 0);
        chk("reset write_en", write_en, 0);
        chk("reset read_en", read_en, 0);
        chk("reset mac_en", mac_en, 0);
        chk("reset bankde", bankde, 0);
        chk("reset wbank_data", wbank_data, 0);
        chk("reset result", result, 0);
        chk("reset done", done, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        build_nom(-1);
        run_tbl("nominal");

        build_nom(8);
        run_tbl("start_busy");

        tv.delete();
        for (int c = 0; c < 23; c++)
            tv.push_back(mk(c == 0, 0, c inside {1, 2, 6, 7}, (c <= 2) ? c - 1 : c - 4, c >= 1 && c <= 20,
                            c >= 1 && c <= 7, c inside {2, 3, 7, 8}, c == 9, c >= 10 && c <= 19, c == 21));
        run_tbl("stall");

        tv.delete();
        for (int c = 0; c < 6; c++)
            tv.push_back(mk(c == 0, c == 2, c == 1 || c == 2, c - 1, c == 1 || c == 2, c == 1, c == 2, 0, 0, 0));
        run_tbl("abort_load");

        imc_val = 14'd999;
        tv.delete();
        for (int c = 0; c < 14; c++)
            tv.push_back(mk(c == 0, c == 10, c >= 1 && c <= 4, c - 1, c >= 1 && c <= 10,
                            c >= 1 && c <= 4, c >= 2 && c <= 5, c == 6, c >= 7 && c <= 10, 0));
        run_tbl("abort_mac");
        chk("abort_mac result_kept", result, 14'd1234);

        tv.delete();
        for (int c = 0; c < 4; c++)
            tv.push_back(mk(c == 0, c == 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_tbl("idle_start_abort");

        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wt_valid = 1'b1;
        wt_data  = beat_row(0);
        @(posedge clk);
        #1 wt_data = beat_row(1);
        @(posedge clk);
        #1 wt_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst busy", busy, 0);
        chk("async_rst wt_ready", wt_ready, 0);
        chk("async_rst write_en", write_en, 0);
        chk("async_rst read_en", read_en, 0);
        chk("async_rst mac_en", mac_en, 0);
        chk("async_rst bankde", bankde, 0);
        chk("async_rst wbank_data", wbank_data, 0);
        chk("async_rst result", result, 0);
        chk("async_rst done", done, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        imc_val = 14'd321;
`ifdef IMC_SEQ_CTRL_REUSE_EN
        reuse_wt = 1'b1;
`endif
        build_nom(-1);
        run_tbl("after_rst");

`ifdef IMC_SEQ_CTRL_REUSE_EN
        imc_val = 14'd777;
        tv.delete();
        for (int c = 0; c < 15; c++)
            tv.push_back(mk(c == 0, 0, 0, 0, c >= 1 && c <= 12, 0, 0, c == 1, c >= 2 && c <= 11, c == 13));
        run_tbl("reuse");
        reuse_wt = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/imc_seq_ctrl.md
Name: imc_seq_ctrl

Overview:
- Sequencer for the in-memory-computing macro: load, then read, then MAC.
- Accepts BANK_COUNT weight beats from a host over a valid/ready channel.
- Issues one write_en pulse per bank, with bankde selecting the bank.
- Then issues one read_en pulse, holds mac_en for MAC_CYCLES cycles, captures the macro's result and pulses done.
- Sits between the host/DMA and the imc datapath. Replaces hand-driven strobes in benches and top level.

Parameters:
- BANK_COUNT, 4, number of weight banks (bankde width = $clog2(BANK_COUNT), min 1).
- LANES, 16, weight elements per bank row.
- WW, 4, bits per weight element.
- MAC_CYCLES, 10, cycles mac_en is held high (>=1).
- RES_W, 14, result width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a job; sampled only in IDLE.
- abort  in  1  cancel job; return to IDLE.
- busy  out  1  high in every state except IDLE.
- wt_valid  in  1  host weight beat valid.
- wt_ready  out  1  controller accepts a beat.
- wt_data  in  LANES*WW  packed row; lane k = bits [k*WW +: WW].
- write_en  out  1  to imc.
- read_en  out  1  to imc.
- mac_en  out  1  to imc.
- bankde  out  $clog2(BANK_COUNT)  bank select to imc.
- wbank_data  out  LANES*WW  registered row to imc Wwbank.
- imc_result  in  RES_W  imc result.
- result  out  RES_W  captured result; holds until the next capture.
- done  out  1  one-cycle pulse when result is updated.

Behaviour:
- Reset (async): state=IDLE; all outputs 0 (write_en, read_en, mac_en, bankde, wbank_data, result, done, busy, wt_ready); bank and MAC counters 0.
- States: IDLE, LOAD, FLUSH, RD, MAC, CAP.
- IDLE: start=1 -> LOAD next cycle, bank_cnt=0.
- LOAD: wt_ready=1 (combinational on state). Handshake = wt_valid & wt_ready.
  - On handshake, register wbank_data<=wt_data, bankde<=bank_cnt, write_en<=1 for exactly the next cycle; bank_cnt++.
  - Back-to-back beats are allowed; gaps (wt_valid=0) are allowed and stall LOAD.
  - Handshake with bank_cnt==BANK_COUNT-1 -> FLUSH.
- FLUSH: one cycle; the final write_en pulse is visible here; wt_ready=0.
- RD: read_en=1 for one cycle; write_en=0.
- MAC: mac_en=1 for exactly MAC_CYCLES consecutive cycles (counter), then CAP.
- CAP: mac_en=0. At end of cycle, result<=imc_result, done<=1, state<=IDLE. done is high in the first IDLE cycle, low after.
- Strobe exclusivity: write_en, read_en, mac_en are never high in the same cycle.
- bankde and wbank_data hold their last value outside write_en cycles.
- abort=1 in any non-IDLE state:
  - Next cycle state=IDLE, all strobes 0, no done, result unchanged.
  - A beat presented in the same cycle as abort is not accepted (wt_ready forced 0).
  - abort in IDLE has no effect; abort has priority over start.
- start while busy: ignored, no queuing.
- Reset mid-job: immediate IDLE; result cleared to 0.
- Latency with 4 back-to-back beats, start in cycle 0:
  - LOAD cycles 1-4; write_en cycles 2-5 (bankde 0,1,2,3).
  - RD cycle 6; MAC cycles 7-16; CAP 17; done cycle 18.
  - Total = 2 + BANK_COUNT + 2 + MAC_CYCLES + 1 for zero-stall loading.

Optional Feature:
- Macro: IMC_SEQ_CTRL_REUSE_EN.
- Defined:
  - Adds input port reuse_wt (1 bit) and internal flag wt_loaded.
  - wt_loaded is set on entering FLUSH; cleared by rst or by abort during LOAD.
  - start with reuse_wt=1 and wt_loaded=1 goes IDLE->RD directly, with no LOAD and no write_en.
  - reuse_wt=1 with wt_loaded=0 behaves as a normal load.
- Undefined: port absent; every job performs LOAD.

Test Plan:
- Nominal job: start at cycle 0, 4 back-to-back beats (bank0 lanes=i, bank1=15-i, bank2=2,4..14 repeating, bank3=1,3..15 repeating), imc_result model=14'd1234 -> write_en cycles 2-5 with bankde 0..3 and matching wbank_data; read_en cycle 6; mac_en cycles 7-16; done cycle 18; result=1234.
- Stalled load: wt_valid low 3 cycles between beats 1 and 2 -> write_en pulses shifted accordingly, no extra pulses, done delayed exactly 3 cycles (cycle 21).
- Abort: abort during MAC cycle 10 -> mac_en 0 from cycle 11, busy 0, done never pulses, result keeps prior value 1234.
- Async reset: assert rst mid-LOAD between clock edges -> all outputs 0 immediately; new start after release runs a full 18-cycle job.
- start during busy: pulse start at cycle 8 -> ignored, single done at cycle 18; start and abort together in IDLE -> stays IDLE.
- With IMC_SEQ_CTRL_REUSE_EN: complete job, then start with reuse_wt=1 -> no write_en, read_en at cycle 1 after start, done at cycle 1+1+MAC_CYCLES+1 (=13).
